// File: rtl/axi_4_lite_mst_pkg.sv
// Shared definitions for the single-outstanding AXI4-Lite master bridge:
// default widths, response codes, PROT value and FSM state encodings.
package axi_4_lite_mst_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WR_B  = 3'd2,
        ST_RD_AR = 3'd3,
        ST_RD_R  = 3'd4,
        ST_RSP   = 3'd5
    } state_e;

    // True for the two error codes a slave can return.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_4_lite_mst_if.sv
// Command/response side plus AXI4-Lite bus of the master bridge.
// The master modport is the bridge's view; slave is the sequencer+slave view.
interface axi_4_lite_mst_if #(
    parameter int unsigned C_AXI_ADDR_WIDTH   = axi_4_lite_mst_pkg::ADDR_WIDTH_DEF,
    parameter int unsigned C_AXI_DATA_WIDTH   = axi_4_lite_mst_pkg::DATA_WIDTH_DEF,
    parameter int unsigned C_AXI_STROBE_WIDTH = C_AXI_DATA_WIDTH / 8
);

    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_write;
    logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr;
    logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata;
    logic [C_AXI_STROBE_WIDTH-1:0] cmd_wstrb;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic                          rsp_write;
    logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata;
    logic [1:0]                    rsp_resp;
    logic                          busy;

    logic                          M_AXI_AWVALID;
    logic                          M_AXI_AWREADY;
    logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]                    M_AXI_AWPROT;
    logic                          M_AXI_WVALID;
    logic                          M_AXI_WREADY;
    logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [C_AXI_STROBE_WIDTH-1:0] M_AXI_WSTRB;
    logic                          M_AXI_BVALID;
    logic                          M_AXI_BREADY;
    logic [1:0]                    M_AXI_BRESP;
    logic                          M_AXI_ARVALID;
    logic                          M_AXI_ARREADY;
    logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]                    M_AXI_ARPROT;
    logic                          M_AXI_RVALID;
    logic                          M_AXI_RREADY;
    logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]                    M_AXI_RRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, busy,
        output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
        input  M_AXI_AWREADY,
        output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        input  M_AXI_WREADY,
        input  M_AXI_BVALID, M_AXI_BRESP,
        output M_AXI_BREADY,
        output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
        input  M_AXI_ARREADY,
        input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
        output M_AXI_RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, busy,
        input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
        output M_AXI_AWREADY,
        input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        output M_AXI_WREADY,
        output M_AXI_BVALID, M_AXI_BRESP,
        input  M_AXI_BREADY,
        input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
        output M_AXI_ARREADY,
        output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/axi_4_lite_mst.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI
// write or read and hands back the response. Every output is a flop.
module axi_4_lite_mst
    import axi_4_lite_mst_pkg::*;
#(
    parameter int unsigned C_AXI_ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int unsigned C_AXI_DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned C_AXI_STROBE_WIDTH = C_AXI_DATA_WIDTH / 8
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESETN,
    axi_4_lite_mst_if.master    bus
);

    state_e                        state_q,     state_d;
    logic                          cmd_ready_q, cmd_ready_d;
    logic                          busy_q,      busy_d;
    logic                          awvalid_q,   awvalid_d;
    logic                          wvalid_q,    wvalid_d;
    logic                          bready_q,    bready_d;
    logic                          arvalid_q,   arvalid_d;
    logic                          rready_q,    rready_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic                          rsp_write_q, rsp_write_d;
    logic [1:0]                    rsp_resp_q,  rsp_resp_d;
    logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [C_AXI_ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [C_AXI_DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [C_AXI_STROBE_WIDTH-1:0] wstrb_q,     wstrb_d;

    always_comb begin
        // NOTE: every _d starts from its _q so no branch below can leave a
        // signal unassigned and infer a latch.
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_ready_q && bus.cmd_valid) begin
                    addr_d = bus.cmd_addr;
                    if (bus.cmd_write) begin
                        wdata_d   = bus.cmd_wdata;
                        wstrb_d   = bus.cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = ST_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = ST_RD_AR;
                    end
                end
            end

            ST_WR: begin
                // AW and W retire independently; a B seen here is ignored.
                if (awvalid_q && bus.M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && bus.M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)        state_d   = ST_WR_B;
            end

            ST_WR_B: begin
                if (bready_q && bus.M_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bus.M_AXI_BRESP;
                    state_d     = ST_RSP;
                end
            end

            ST_RD_AR: begin
                if (arvalid_q && bus.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_R;
                end
            end

            ST_RD_R: begin
                if (rready_q && bus.M_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = bus.M_AXI_RDATA;
                    rsp_resp_d  = bus.M_AXI_RRESP;
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Registered copies of "next state is IDLE", so cmd_ready rises the
        // cycle after the response handshake and never in the same cycle.
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            // NOTE: the address/data holding registers are reset as well,
            // because they drive bus outputs that must read 0 out of reset.
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= RESP_OKAY;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            // NOTE: non-blocking here so every flop samples pre-edge values.
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.busy          = busy_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_write     = rsp_write_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;

    assign bus.M_AXI_AWVALID = awvalid_q;
    assign bus.M_AXI_AWADDR  = addr_q;
    assign bus.M_AXI_AWPROT  = PROT_DEFAULT;
    assign bus.M_AXI_WVALID  = wvalid_q;
    assign bus.M_AXI_WDATA   = wdata_q;
    assign bus.M_AXI_WSTRB   = wstrb_q;
    assign bus.M_AXI_BREADY  = bready_q;
    assign bus.M_AXI_ARVALID = arvalid_q;
    assign bus.M_AXI_ARADDR  = addr_q;
    assign bus.M_AXI_ARPROT  = PROT_DEFAULT;
    assign bus.M_AXI_RREADY  = rready_q;

    // A write response before both AW and W completed is a slave protocol error.
    b_before_aw_w_done: assert property (
        @(posedge M_AXI_ACLK) disable iff (!M_AXI_ARESETN)
        !(state_q == ST_WR && bus.M_AXI_BVALID && bready_q)
    );

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Directed bench for axi_4_lite_mst: a negedge-driven AXI4-Lite slave BFM
// with per-channel delays, and a scoreboard of expected command responses.
module tb_axi_4_lite_mst;
    import axi_4_lite_mst_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_4_lite_mst_if #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW)) bus ();

    axi_4_lite_mst #(
        .C_AXI_ADDR_WIDTH(AW),
        .C_AXI_DATA_WIDTH(DW)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .bus          (bus)
    );

    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Slave BFM configuration, written by the sequence between transactions.
    int         aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0] bresp_cfg = RESP_OKAY;
    logic [1:0] rresp_cfg = RESP_OKAY;

    logic [DW-1:0] mem [0:15];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave BFM: acts on falling edges, so values it drives are stable at the
    // next rising edge; a handshake seen now completes at that rising edge.
    initial begin : slave_bfm
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit aw_got, w_got, ar_got;
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic [AW-1:0] s_waddr, s_raddr;
        logic [DW-1:0] s_wdata;
        logic [SW-1:0] s_wstrb;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, ar_got} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        s_waddr = '0; s_raddr = '0; s_wdata = '0; s_wstrb = '0;
        bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
        bus.M_AXI_BVALID  = 1'b0; bus.M_AXI_BRESP  = RESP_OKAY;
        bus.M_AXI_ARREADY = 1'b0; bus.M_AXI_RVALID = 1'b0;
        bus.M_AXI_RDATA   = '0;   bus.M_AXI_RRESP  = RESP_OKAY;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                {aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got, ar_got} = '0;
                {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
                bus.M_AXI_AWREADY = 1'b0; bus.M_AXI_WREADY = 1'b0;
                bus.M_AXI_BVALID  = 1'b0; bus.M_AXI_ARREADY = 1'b0;
                bus.M_AXI_RVALID  = 1'b0;
            end else begin
                if (aw_hs) begin bus.M_AXI_AWREADY = 1'b0; aw_got = 1'b1; s_waddr = bus.M_AXI_AWADDR; end
                if (w_hs) begin
                    bus.M_AXI_WREADY = 1'b0; w_got = 1'b1;
                    s_wdata = bus.M_AXI_WDATA; s_wstrb = bus.M_AXI_WSTRB;
                end
                if (b_hs) begin
                    bus.M_AXI_BVALID = 1'b0; aw_got = 1'b0; w_got = 1'b0;
                    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end
                if (ar_hs) begin bus.M_AXI_ARREADY = 1'b0; ar_got = 1'b1; s_raddr = bus.M_AXI_ARADDR; end
                if (r_hs) begin bus.M_AXI_RVALID = 1'b0; ar_got = 1'b0; ar_cnt = 0; r_cnt = 0; end

                if (bus.M_AXI_AWVALID && !aw_got && !bus.M_AXI_AWREADY) begin
                    if (aw_cnt >= aw_lat) bus.M_AXI_AWREADY = 1'b1; else aw_cnt++;
                end
                if (bus.M_AXI_WVALID && !w_got && !bus.M_AXI_WREADY) begin
                    if (w_cnt >= w_lat) bus.M_AXI_WREADY = 1'b1; else w_cnt++;
                end
                if (aw_got && w_got && !bus.M_AXI_BVALID) begin
                    if (b_cnt >= b_lat) begin
                        for (int b = 0; b < int'(SW); b++)
                            if (s_wstrb[b]) mem[s_waddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                        bus.M_AXI_BVALID = 1'b1;
                        bus.M_AXI_BRESP  = bresp_cfg;
                    end else b_cnt++;
                end
                if (bus.M_AXI_ARVALID && !ar_got && !bus.M_AXI_ARREADY) begin
                    if (ar_cnt >= ar_lat) bus.M_AXI_ARREADY = 1'b1; else ar_cnt++;
                end
                if (ar_got && !bus.M_AXI_RVALID) begin
                    if (r_cnt >= r_lat) begin
                        bus.M_AXI_RVALID = 1'b1;
                        bus.M_AXI_RDATA  = mem[s_raddr[5:2]];
                        bus.M_AXI_RRESP  = rresp_cfg;
                    end else r_cnt++;
                end

                aw_hs = bus.M_AXI_AWREADY && bus.M_AXI_AWVALID;
                w_hs  = bus.M_AXI_WREADY  && bus.M_AXI_WVALID;
                b_hs  = bus.M_AXI_BVALID  && bus.M_AXI_BREADY;
                ar_hs = bus.M_AXI_ARREADY && bus.M_AXI_ARVALID;
                r_hs  = bus.M_AXI_RVALID  && bus.M_AXI_RREADY;
            end
        end
    end

    // Present a command, queue its expected response, and return on the
    // falling edge of cycle 1 (the cycle after the accepting rising edge).
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [SW-1:0] wstrb, input logic [DW-1:0] exp_rdata,
                            input logic [1:0] exp_resp);
        int n;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_wstrb = wstrb;
        e.write = wr; e.rdata = wr ? '0 : exp_rdata; e.resp = exp_resp;
        sb.push_back(e);
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (bus.cmd_ready !== 1'b1) check("cmd_accept_timeout", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid and compare it with the oldest expectation.
    task automatic wait_rsp(output int waited);
        exp_t e;
        waited = 0;
        while (bus.rsp_valid !== 1'b1 && waited < 60) begin @(negedge clk); waited++; end
        if (bus.rsp_valid !== 1'b1) begin
            check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
        end else if (sb.size() == 0) begin
            check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            check("rsp_write", 32'(bus.rsp_write), 32'(e.write));
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_resp",  32'(bus.rsp_resp), 32'(e.resp));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : sequence_main
        int lat;
        bit seen;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0;   bus.cmd_wstrb = '0;   bus.rsp_ready = 1'b1;

        // Reset held with a command pending: nothing may move.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 32'h4;
        bus.cmd_wdata = 32'hCAFE_F00D; bus.cmd_wstrb = 4'hF;
        rst_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("reset_handshakes",
                  32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID,
                       bus.M_AXI_RREADY, bus.cmd_ready, bus.busy, bus.rsp_valid}), 32'd0);
        end
        check("reset_awaddr", bus.M_AXI_AWADDR, 32'd0);
        check("reset_araddr", bus.M_AXI_ARADDR, 32'd0);
        check("reset_wdata",  bus.M_AXI_WDATA,  32'd0);
        check("reset_wstrb",  32'(bus.M_AXI_WSTRB), 32'd0);
        check("reset_rsp",    32'({bus.rsp_rdata, bus.rsp_resp}), 32'd0);
        check("prot",         32'({bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}), 32'd0);
        bus.cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", 32'(bus.cmd_ready), 32'd1);
        check("busy_after_reset",      32'(bus.busy),      32'd0);

        // Write then read back at minimum latency.
        send_cmd(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, '0, RESP_OKAY);
        check("wr_cycle1_valids", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.busy}), 32'hF);
        wait_rsp(lat);
        check("wr_min_latency", 32'(lat), 32'd2);
        send_cmd(1'b0, 32'h4, '0, '0, 32'hDEAD_BEEF, RESP_OKAY);
        check("rd_cycle1_valids", 32'({bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.M_AXI_ARADDR[7:0]}), 32'h304);
        wait_rsp(lat);
        check("rd_min_latency", 32'(lat), 32'd2);

        // Partial strobe merges one byte into a full word.
        send_cmd(1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, '0, RESP_OKAY);
        wait_rsp(lat);
        send_cmd(1'b1, 32'h4, 32'h0000_00AA, 4'h1, '0, RESP_OKAY);
        wait_rsp(lat);
        send_cmd(1'b0, 32'h4, '0, '0, 32'hFFFF_FFAA, RESP_OKAY);
        wait_rsp(lat);

        // Skewed AW/W with a late SLVERR write response.
        aw_lat = 1; w_lat = 5; b_lat = 1; bresp_cfg = RESP_SLVERR;
        send_cmd(1'b1, 32'h8, 32'h0000_0055, 4'h3, '0, RESP_SLVERR);
        check("skew_awaddr", bus.M_AXI_AWADDR, 32'h8);
        check("skew_wdata",  bus.M_AXI_WDATA,  32'h55);
        check("skew_wstrb",  32'(bus.M_AXI_WSTRB), 32'h3);
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("skew_awvalid_c%0d", c), 32'(bus.M_AXI_AWVALID), 32'(c <= 2));
            check($sformatf("skew_wvalid_c%0d", c),  32'(bus.M_AXI_WVALID),  32'(c <= 6));
            check($sformatf("skew_bready_c%0d", c),  32'(bus.M_AXI_BREADY),  32'd1);
            @(negedge clk);
        end
        wait_rsp(lat);
        check("skew_rsp_cycle9", 32'(lat), 32'd0);
        check("skew_resp_is_error", 32'(resp_is_error(bus.rsp_resp)), 32'd1);
        aw_lat = 0; w_lat = 0; b_lat = 0; bresp_cfg = RESP_OKAY;

        // Response backpressure with a command presented meanwhile.
        send_cmd(1'b1, 32'hC, 32'h1234_5678, 4'hF, '0, RESP_OKAY);
        wait_rsp(lat);
        send_cmd(1'b0, 32'hC, '0, '0, 32'h1234_5678, RESP_OKAY);
        bus.rsp_ready = 1'b0;
        wait_rsp(lat);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h4;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold", 32'({bus.rsp_valid, bus.cmd_ready, bus.M_AXI_ARVALID, bus.busy}), 32'h9);
            check("bp_rdata", bus.rsp_rdata, 32'h1234_5678);
        end
        bus.rsp_ready = 1'b1;
        send_cmd(1'b0, 32'h4, '0, '0, 32'hFFFF_FFAA, RESP_OKAY);
        check("bp_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
        wait_rsp(lat);

        // Zero-strobe write is issued but leaves memory untouched.
        send_cmd(1'b1, 32'hC, 32'hFFFF_FFFF, 4'h0, '0, RESP_OKAY);
        check("zero_strb_issued", 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, 4'(bus.M_AXI_WSTRB)}), 32'h30);
        wait_rsp(lat);
        send_cmd(1'b0, 32'hC, '0, '0, 32'h1234_5678, RESP_OKAY);
        wait_rsp(lat);

        // Asynchronous reset while W is still waiting for WREADY.
        w_lat = 20;
        send_cmd(1'b1, 32'h4, 32'h0, 4'hF, '0, RESP_OKAY);
        repeat (2) @(negedge clk);
        check("mid_wr_wvalid_before", 32'({bus.M_AXI_WVALID, bus.M_AXI_BREADY}), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.busy, bus.cmd_ready}), 32'd0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w_lat = 0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        check("no_rsp_after_reset", 32'(seen), 32'd0);
        send_cmd(1'b0, 32'h4, '0, '0, 32'hFFFF_FFAA, RESP_OKAY);
        wait_rsp(lat);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_4_lite_mst.md
Name: axi_4_lite_mst

Overview:
- Single-outstanding AXI4-Lite master bridge. It sits directly upstream of axi_4_lite_slv.
- Converts a simple command/response interface (from a CPU model, test sequencer or control FSM) into AXI4-Lite write and read transactions.
- Returns read data and response codes to the command side.

Parameters:
- C_AXI_ADDR_WIDTH, 32, address width; must match the slave.
- C_AXI_DATA_WIDTH, 32, data width; multiple of 8.
- C_AXI_STROBE_WIDTH, C_AXI_DATA_WIDTH/8, byte-strobe width.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR  byte address.
- cmd_wdata  in  DATA  write data.
- cmd_wstrb  in  STRB  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP copy (OKAY=2'b00, SLVERR=2'b10).
- busy  out  1  high in any state other than IDLE.
- M_AXI_AWVALID  out  1.
- M_AXI_AWREADY  in  1.
- M_AXI_AWADDR  out  ADDR.
- M_AXI_AWPROT  out  3  constant 3'b000.
- M_AXI_WVALID  out  1.
- M_AXI_WREADY  in  1.
- M_AXI_WDATA  out  DATA.
- M_AXI_WSTRB  out  STRB.
- M_AXI_BVALID  in  1.
- M_AXI_BREADY  out  1.
- M_AXI_BRESP  in  2.
- M_AXI_ARVALID  out  1.
- M_AXI_ARREADY  in  1.
- M_AXI_ARADDR  out  ADDR.
- M_AXI_ARPROT  out  3  constant 3'b000.
- M_AXI_RVALID  in  1.
- M_AXI_RREADY  out  1.
- M_AXI_RDATA  in  DATA.
- M_AXI_RRESP  in  2.

Behaviour:

Interface
- One clock, M_AXI_ACLK. Reset M_AXI_ARESETN is asynchronous, active-low.
- All outputs are registered.

Reset
- All VALID/READY outputs are 0.
- rsp_valid=0, busy=0.
- Address, data and strobe outputs are 0; rsp_resp=2'b00.
- State is IDLE.
- Reset asserted mid-transaction: all outputs drop immediately and no response is produced. The in-flight command is lost, and the slave is reset by the same net.

States: IDLE, WR (AW/W issue), WR_B, RD_AR, RD_R, RSP.

IDLE
- cmd_ready=1 only in IDLE.
- On accept of a write: latch addr/wdata/wstrb; next cycle AWVALID=1, WVALID=1, BREADY=1; go to WR.
- On accept of a read: latch addr; next cycle ARVALID=1, RREADY=1; go to RD_AR.

WR
- AWVALID and WVALID deassert independently, the cycle after their own handshake.
- WVALID must stay high until WREADY, even if AWREADY comes first. WREADY may arrive several cycles after AW.
- Once both handshakes are done: go to WR_B.
- BREADY is held at 1 from command accept until the B handshake. The downstream slave requires BREADY high while WREADY is high.
- A B handshake arriving before both AW and W handshakes is a protocol error. It is ignored and flagged by a simulation-only assertion.

WR_B
- On BVALID&&BREADY: BREADY→0; capture BRESP; rsp_write=1; rsp_rdata=0; go to RSP.

RD_AR
- On ARVALID&&ARREADY: ARVALID→0; go to RD_R. RREADY stays 1.

RD_R
- On RVALID&&RREADY: RREADY→0; capture RDATA and RRESP; rsp_write=0; go to RSP.

RSP
- rsp_valid=1; response fields held stable until rsp_ready.
- On rsp_valid&&rsp_ready: rsp_valid→0; go to IDLE. cmd_ready=1 the following cycle, so there are no back-to-back accepts.

Ordering and values
- Exactly one transaction outstanding; responses are in command order by construction.
- Addresses pass through unmodified; no alignment or range check.
- Zero-strobe write (wstrb=0) is issued normally.
- cmd inputs are ignored while cmd_ready=0.

Minimum latency
- Write: command accept cycle 0 → AWVALID/WVALID at cycle 1 → rsp_valid no earlier than cycle 3.
- Read: ARVALID at cycle 1 → rsp_valid no earlier than cycle 3.

Decomposition:
- Shared include, next to the existing configuration header:
  - Response codes OKAY/EXOKAY/SLVERR/DECERR.
  - State encodings (3-bit localparams).
  - Default PROT value.
  - Width macros reused from the existing header.
- No sub-module. A separate testbench top instantiates axi_4_lite_mst driving axi_4_lite_slv.

Test Plan:
- Reset: hold ARESETN=0 for 5 cycles with cmd_valid=1 → all AXI VALID/READY=0, cmd_ready=0, busy=0. Release → cmd_ready=1.
- Write then read against axi_4_lite_slv: write addr 0x4, data 0xDEADBEEF, strb 4'hF → rsp_write=1, rsp_resp=00. Read addr 0x4 → rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Partial strobe: write 0xFFFFFFFF strb 4'hF, then 0x000000AA strb 4'h1 to the same addr → read returns 0xFFFFFFAA.
- Skewed channels with a BFM slave: AWREADY at cycle 2, WREADY at cycle 6 → AWVALID low from cycle 3, WVALID high through cycle 6, BREADY continuously 1. BVALID at cycle 8 with BRESP=10 → rsp_resp=10.
- Response backpressure: rsp_ready=0 for 10 cycles after a read of 0x12345678 → rsp_valid and rsp_rdata stable, cmd_ready=0, no new ARVALID. rsp_ready=1 → IDLE, next command accepted.
- Async reset mid-write: drop ARESETN between clock edges while WVALID=1 → WVALID and BREADY go 0 without waiting for a clock edge, and no rsp_valid follows.
